// File: rtl/biphasemark_encode.sv
// biphasemark_encode: S/PDIF-style biphase-mark subframe serializer with Z/X/Y preamble and block tracking
module biphasemark_encode #(
  parameter int FRAMES_PER_BLOCK = 192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  aux_in,
  input  logic [19:0] audio_in,
  input  logic        v_in,
  input  logic        u_in,
  input  logic        c_in,
  input  logic        pin_valid,
  output logic        pin_ready,
  output logic        dout,
  output logic        vout,
  output logic [7:0]  frame_counter,
  output logic        channel
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
  state_t      state, state_d;
  logic [5:0]  hc;
  logic [26:0] hold;
  logic        hold_full;
  logic [27:0] sr;
  logic        last_level;
  logic        pos_ch;
  logic [7:0]  pos_fc;
  logic [7:0]  pat;
  logic        last, accept, xfer, bit_d;
  assign pin_ready = !hold_full;
  assign accept = pin_valid && !hold_full;
  always_comb begin
    last = hc == 6'd63;
    xfer = hold_full && (state == IDLE || (state == DATA && last));
    pat = pos_ch ? 8'b11100100 : (pos_fc == 8'd0 ? 8'b11101000 : 8'b11100010);
    state_d = state == IDLE ? (hold_full ? PREAMBLE : IDLE) :
              state == PREAMBLE ? (hc == 6'd7 ? DATA : PREAMBLE) :
              (last ? (hold_full ? PREAMBLE : IDLE) : DATA);
    // data slots: forced transition at slot start, mid-slot transition only for a 1
    bit_d = state == PREAMBLE ? pat[~hc[2:0]] ^ last_level : (hc[0] ? dout ^ sr[0] : !dout);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hc <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      sr <= '0;
      last_level <= 1'b0;
      pos_ch <= 1'b0;
      pos_fc <= '0;
      dout <= 1'b0;
      vout <= 1'b0;
      frame_counter <= '0;
      channel <= 1'b0;
    end else begin
      state <= state_d;
      hold_full <= accept || (hold_full && !xfer);
      if (accept) hold <= {c_in, u_in, v_in, audio_in, aux_in};
      if (state == IDLE) begin
        vout <= 1'b0;
        channel <= 1'b0;
        frame_counter <= '0;
        hc <= '0;
      end else begin
        vout <= 1'b1;
        dout <= bit_d;
        channel <= pos_ch;
        frame_counter <= pos_fc;
        hc <= hc + 6'd1;
        if (state == DATA && hc[0]) sr <= sr >> 1;
        if (last) last_level <= bit_d;
      end
      if (xfer) sr <= {^hold, hold};
      // position advances only at a subframe boundary; an underrun restarts the block
      if (state == DATA && last) begin
        pos_ch <= hold_full && !pos_ch;
        pos_fc <= !hold_full ? 8'd0 :
                  pos_ch ? (pos_fc == 8'(FRAMES_PER_BLOCK - 1) ? 8'd0 : pos_fc + 8'd1) : pos_fc;
      end
    end
  end
endmodule

// File: tb/tb_biphasemark_encode.sv
// tb_biphasemark_encode: directed-vector bench for the biphase-mark subframe encoder
module tb_biphasemark_encode;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  aux_in = '0;
  logic [19:0] audio_in = '0;
  logic        v_in = 1'b0, u_in = 1'b0, c_in = 1'b0, pin_valid = 1'b0;
  logic        pin_ready, dout, vout, channel;
  logic [7:0]  frame_counter;
  int total = 0, passed = 0;
  localparam logic [55:0] BODY_F = 56'hCC_AAAAAAAAAA_CC;
  localparam logic [55:0] BODY_Z = 56'hCC_CCCCCCCCCC_CC;
  localparam logic [55:0] BODY_O = 56'hCC_B333333333_32;
  localparam logic [7:0]  PZ = 8'hE8, PX = 8'hE2, PY = 8'hE4;

  biphasemark_encode dut (
    .clk(clk), .rst(rst), .aux_in(aux_in), .audio_in(audio_in), .v_in(v_in),
    .u_in(u_in), .c_in(c_in), .pin_valid(pin_valid), .pin_ready(pin_ready),
    .dout(dout), .vout(vout), .frame_counter(frame_counter), .channel(channel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send(input logic [19:0] au);
    int n = 0;
    @(negedge clk);
    while (!pin_ready && n < 400) begin n++; @(negedge clk); end
    audio_in = au;
    pin_valid = 1'b1;
    @(negedge clk);
    pin_valid = 1'b0;
  endtask

  task automatic get_sub(output logic [63:0] v, output logic [7:0] fc, output logic ch,
                         output int waits, output logic stable);
    waits = 0;
    v = '0;
    @(negedge clk);
    while (!vout && waits < 400) begin waits++; @(negedge clk); end
    fc = frame_counter;
    ch = channel;
    stable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i != 0) @(negedge clk);
      v = {v[62:0], dout};
      if (!vout || frame_counter != fc || channel != ch) stable = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    pin_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [63:0] v;
  logic [7:0]  fc;
  logic        ch, st;
  int          w;

  initial begin
    repeat (2) @(negedge clk);
    check("reset", {dout, vout, frame_counter, channel, pin_ready}, {1'b0, 1'b0, 8'd0, 1'b0, 1'b1});
    rst = 1'b0;
    // single payload, then underrun to idle
    send(20'hFFFFF);
    get_sub(v, fc, ch, w, st);
    check("single_latency", 64'(w), 64'd1);
    check("single_vec", v, {PZ, BODY_F});
    check("single_pos", {fc, ch}, 9'd0);
    check("single_stable", 64'(st), 64'd1);
    @(negedge clk);
    check("single_after", {vout, dout, pin_ready}, 3'b001);
    // all-zero payload
    send(20'h00000);
    get_sub(v, fc, ch, w, st);
    check("zero_vec", v, {PZ, BODY_Z});
    check("zero_last", 64'(v[0]), 64'd0);
    // odd data: parity 1, next preamble uninverted
    fork
      begin send(20'h00001); send(20'h00001); end
      begin
        get_sub(v, fc, ch, w, st);
        check("odd_vec0", v, {PZ, BODY_O});
        get_sub(v, fc, ch, w, st);
        check("odd_vec1", v, {PY, BODY_O});
        check("odd_pos1", {fc, ch, st, 1'(w == 0)}, {8'd0, 1'b1, 1'b1, 1'b1});
      end
    join
    @(negedge clk);
    check("odd_after", {vout, dout}, 2'b00);
    pulse_reset();
    // continuous stream across a block wrap
    audio_in = 20'hFFFFF;
    pin_valid = 1'b1;
    for (int i = 0; i < 386; i++) begin
      get_sub(v, fc, ch, w, st);
      check($sformatf("cont_vec%0d", i), v,
            {(i % 384 == 0) ? PZ : (i % 2 == 1) ? PY : PX, BODY_F});
      check($sformatf("cont_pos%0d", i), {fc, ch, st, 1'(i == 0 || w == 0)},
            {8'((i / 2) % 192), 1'(i % 2), 1'b1, 1'b1});
    end
    pulse_reset();
    // underrun after three subframes
    fork
      begin send(20'hFFFFF); send(20'hFFFFF); send(20'hFFFFF); end
      begin
        get_sub(v, fc, ch, w, st);
        check("ur_vec0", v, {PZ, BODY_F});
        get_sub(v, fc, ch, w, st);
        check("ur_vec1", {v, fc, ch, 1'(w == 0)}, {PY, BODY_F, 8'd0, 1'b1, 1'b1});
        get_sub(v, fc, ch, w, st);
        check("ur_vec2", {v, fc, ch, 1'(w == 0)}, {PX, BODY_F, 8'd1, 1'b0, 1'b1});
        @(negedge clk);
        check("ur_drop", {vout, dout, frame_counter, channel}, 11'd0);
      end
    join
    repeat (100) @(negedge clk);
    send(20'hFFFFF);
    get_sub(v, fc, ch, w, st);
    check("ur_resume", {v, fc, ch}, {PZ, BODY_F, 8'd0, 1'b0});
    // reset mid-subframe with a payload pending
    fork
      begin send(20'hFFFFF); send(20'hFFFFF); send(20'hFFFFF); end
      begin
        get_sub(v, fc, ch, w, st);
        repeat (21) @(negedge clk);
      end
    join
    check("pre_reset", {vout, channel, pin_ready}, 3'b110);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", {dout, vout, frame_counter, channel, pin_ready}, {1'b0, 1'b0, 8'd0, 1'b0, 1'b1});
    rst = 1'b0;
    send(20'h00000);
    get_sub(v, fc, ch, w, st);
    check("post_reset", {v, fc, ch}, {PZ, BODY_Z, 8'd0, 1'b0});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/biphasemark_encode.md
Name: biphasemark_encode

Overview:
- S/PDIF-style biphase-mark transmitter; the counterpart of biphasemark_decode on the optical link.
- Accepts one subframe payload per handshake and serializes it MSB-in-time as 64 half-cells, one per clk: 8 preamble half-cells followed by 28 BMC slots (aux, audio, V, U, C, P).
- Tracks channel A/B and the 192-frame block, inserting Z/X/Y preambles, so its dout/vout drive biphasemark_decode din/vin directly.

Parameters:
FRAMES_PER_BLOCK, 192, frames per channel-status block; frame_counter wraps to 0 after FRAMES_PER_BLOCK-1.

Ports:
clk  in  1  system clock; one half-cell per cycle
rst  in  1  synchronous, active-high reset
aux_in  in  4  aux bits, slots 4-7, aux_in[0] sent first
audio_in  in  20  audio sample, slots 8-27, LSB first
v_in  in  1  validity bit, slot 28
u_in  in  1  user bit, slot 29
c_in  in  1  channel-status bit, slot 30
pin_valid  in  1  payload valid
pin_ready  out  1  holding register empty
dout  out  1  BMC half-cell output
vout  out  1  high while a subframe half-cell is being driven
frame_counter  out  8  frame index (0..191) of the subframe on dout
channel  out  1  0 = A, 1 = B for the subframe on dout

Behaviour:
- Reset state: dout=0, vout=0, frame_counter=0, channel=0, pin_ready=1, holding register empty, FSM=IDLE, last_level=0. Reset mid-subframe aborts it; the next payload starts with Z.
- Handshake: accept on pin_valid && pin_ready into a 27-bit holding register. pin_ready = !hold_full. Accept and transfer in the same cycle are legal.
- Parity P (slot 31) = XOR of the 27 payload bits, giving even parity over slots 4-31.
- FSM states: IDLE, PREAMBLE, DATA. A 6-bit half-cell counter hc runs 0..63.
- IDLE -> PREAMBLE: the cycle after hold_full becomes 1. The payload moves to the shift register, and hold is freed in that same cycle.
- Latency from acceptance in IDLE to the first half-cell (vout=1) is 2 cycles.
- PREAMBLE (hc 0-7) drives the pattern MSB first, XORed with last_level:
  - Z = 8'b11101000 when channel=0 and frame_counter=0.
  - X = 8'b11100010 when channel=0 and frame_counter!=0.
  - Y = 8'b11100100 when channel=1.
- DATA (hc 8-63), slot k = (hc-8)/2:
  - First half of each slot is !level (transition at the slot start).
  - Second half is the first half XOR the bit (mid-slot transition only for 1).
  - Registered output; last_level tracks dout.
- At hc=63:
  - If hold_full: load the next payload, go to PREAMBLE at hc=0 with no gap, and advance position:
    - channel toggles.
    - When channel goes 1->0, frame_counter increments, wrapping FRAMES_PER_BLOCK-1 -> 0.
  - Else (underrun): go to IDLE. vout=0 next cycle, dout holds last level, frame_counter=0, channel=0. The stream restarts with Z.
- frame_counter and channel change only on subframe boundaries and are stable for all 64 half-cells.
- Even parity guarantees last_level=0 at every subframe end. The preamble inversion rule is still applied.

Test Plan:
- Single payload: aux=0, audio=20'hFFFFF, V=U=C=0, then pin_valid=0 -> vout=1 for exactly 64 cycles. dout MSB-first = 64'hE8_CC_AAAAAAAAAA_CC, frame_counter=0, channel=0. Afterwards vout=0, dout=0, pin_ready=1.
- All-zero payload -> dout = 64'hE8_CC_CCCCCCCCCC_CC, P=0, last half-cell 0.
- Odd data: audio=20'h00001, rest 0 -> P=1, slot 31 shows a mid-slot transition, dout ends at 0, next preamble uninverted.
- Continuous: 386 payloads with pin_valid held high -> vout never drops.
  - Preambles Z,Y,X,Y,...,X,Y, then Z again at subframe 384.
  - frame_counter 0..191 then 0, channel alternating 0/1.
  - Each subframe dout matches the single-payload vector.
- Underrun: supply 3 payloads, stall 100 cycles, resume -> vout falls after the 3rd subframe (192 cycles after the first half-cell). The resumed stream starts with E8 with frame_counter=0, channel=0.
- Reset at hc=20 of a subframe -> next cycle vout=0, dout=0, pin_ready=1, counters 0. The following payload starts with Z.
